// File: rtl/lsu_mem_stage_if.sv
// Memory bus between the load/store stage (master) and the memory system (slave).
// Single-transaction req/gnt handshake with a separate rvalid read-data return.
interface lsu_mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one bus transaction per accepted op, byte-lane stores, extended loads, timeout abort.
// Optional LSU_MISALIGN_TRAP_EN: misaligned ops abort with wb_err instead of being size-aligned.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_ex_valid,
   output logic                 o_ex_ready,
   input  logic                 i_ex_is_store,
   input  logic [1:0]           i_ex_size,
   input  logic                 i_ex_unsigned,
   input  logic [63:0]          i_ex_addr,
   input  logic [63:0]          i_ex_wdata,
   lsu_mem_stage_if.master      mem,
   output logic                 o_wb_valid,
   output logic [63:0]          o_wb_data,
   output logic                 o_wb_err,
   output logic                 o_stall
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_cnt;
   logic        r_err;
   logic [63:0] r_wb_data;
   logic        r_store;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [2:0]  r_off;
   logic [60:0] r_addr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;

   logic        w_accept;
   logic        w_set_err;
   logic        w_capture;
   logic        w_timeout;
   logic [3:0]  w_bytes;
   logic [2:0]  w_align_mask;
   logic [2:0]  w_off;
   logic        w_misalign;
   logic [15:0] w_mask16;
   logic [63:0] w_wdata_sh;
   logic [63:0] w_ld_raw;
   logic [63:0] w_ld_ext;

   // Lane geometry of the op being offered; the 3-bit subtraction wraps 8 bytes to mask 7.
   assign w_bytes      = 4'd1 << i_ex_size;
   assign w_align_mask = w_bytes[2:0] - 3'd1;
`ifdef LSU_MISALIGN_TRAP_EN
   assign w_off        = i_ex_addr[2:0];
   assign w_misalign   = |(i_ex_addr[2:0] & w_align_mask);
`else
   assign w_off        = i_ex_addr[2:0] & ~w_align_mask;
   assign w_misalign   = 1'b0;
`endif
   assign w_mask16     = ((16'd1 << w_bytes) - 16'd1) << w_off;
   assign w_wdata_sh   = i_ex_wdata << {w_off, 3'b000};

   assign w_ld_raw     = mem.mem_rdata >> {r_off, 3'b000};
   always_comb begin
      w_ld_ext = w_ld_raw;
      case (r_size)
         2'd0: w_ld_ext = r_unsigned ? {56'd0, w_ld_raw[7:0]}  : {{56{w_ld_raw[7]}},  w_ld_raw[7:0]};
         2'd1: w_ld_ext = r_unsigned ? {48'd0, w_ld_raw[15:0]} : {{48{w_ld_raw[15]}}, w_ld_raw[15:0]};
         2'd2: w_ld_ext = r_unsigned ? {32'd0, w_ld_raw[31:0]} : {{32{w_ld_raw[31]}}, w_ld_raw[31:0]};
         default: w_ld_ext = w_ld_raw;
      endcase
   end

   assign w_accept  = i_ex_valid && (r_state == S_IDLE);
   assign w_timeout = (r_cnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // A completing handshake wins over a timeout that expires in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_set_err    = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_misalign ? S_RESP : S_REQ;
               w_set_err    = w_misalign;
            end
         end
         S_REQ: begin
            if (mem.mem_gnt && (r_store || mem.mem_rvalid)) begin
               w_state_next = S_RESP;
               w_capture    = !r_store;
            end else if (w_timeout) begin
               w_state_next = S_RESP;
               w_set_err    = 1'b1;
            end else if (mem.mem_gnt) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.mem_rvalid) begin
               w_state_next = S_RESP;
               w_capture    = 1'b1;
            end else if (w_timeout) begin
               w_state_next = S_RESP;
               w_set_err    = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_wb_data  <= '0;
         r_store    <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_off      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wmask    <= '0;
      end else if (w_accept) begin
         r_cnt      <= '0;
         r_err      <= w_set_err;
         r_wb_data  <= '0;
         r_store    <= i_ex_is_store;
         r_size     <= i_ex_size;
         r_unsigned <= i_ex_unsigned;
         r_off      <= w_off;
         r_addr     <= i_ex_addr[63:3];
         r_wdata    <= w_wdata_sh;
         r_wmask    <= w_mask16[7:0];
      end else begin
         if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
         if (w_set_err) r_err <= 1'b1;
         if (w_capture) r_wb_data <= w_ld_ext;
      end
   end

   assign o_ex_ready    = (r_state == S_IDLE);
   assign o_stall       = ~o_ex_ready;
   assign o_wb_valid    = (r_state == S_RESP);
   assign o_wb_err      = (r_state == S_RESP) && r_err;
   assign o_wb_data     = (r_state == S_RESP && !r_err) ? r_wb_data : 64'd0;

   assign mem.mem_req   = (r_state == S_REQ);
   assign mem.mem_we    = r_store;
   assign mem.mem_addr  = {r_addr, 3'b000};
   assign mem.mem_wdata = r_wdata;
   assign mem.mem_wmask = r_wmask;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed + randomized bench for lsu_mem_stage against a byte-level reference model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_lsu_mem_stage;
   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_is_store = 1'b0;
   logic [1:0]  ex_size = 2'd0;
   logic        ex_unsigned = 1'b0;
   logic [63:0] ex_addr = 64'd0;
   logic [63:0] ex_wdata = 64'd0;
   logic        ex_ready, wb_valid, wb_err, stall;
   logic [63:0] wb_data;
   int          n_assert = 0;
   int          n_fail = 0;

   lsu_mem_stage_if bus();

   lsu_mem_stage #(.TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_ex_valid  (ex_valid),
      .o_ex_ready  (ex_ready),
      .i_ex_is_store(ex_is_store),
      .i_ex_size   (ex_size),
      .i_ex_unsigned(ex_unsigned),
      .i_ex_addr   (ex_addr),
      .i_ex_wdata  (ex_wdata),
      .mem         (bus),
      .o_wb_valid  (wb_valid),
      .o_wb_data   (wb_data),
      .o_wb_err    (wb_err),
      .o_stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: pick the addressed bytes, then zero- or sign-fill above them.
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                              input int bytes, input bit uns);
      logic [63:0] v;
      logic [63:0] m;
      v = rdata >> (8 * off);
      if (bytes == 8) return v;
      m = (64'd1 << (8 * bytes)) - 64'd1;
      v = v & m;
      if (!uns && v[8*bytes-1]) v = v | ~m;
      return v;
   endfunction

   task automatic do_op(input bit st, input int sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int gd, input int rd, input string tag);
      int          bytes;
      int          off;
      bit          trap;
      logic [7:0]  mask;
      logic [63:0] expd;
      bytes = 1 << sz;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (addr % 64'(bytes)) != 0;
      off  = int'(addr % 8);
`else
      trap = 1'b0;
      off  = int'(addr % 8) - (int'(addr % 8) % bytes);
`endif
      mask = 8'(((1 << bytes) - 1) << off);
      expd = st ? 64'd0 : model_load(rdata, off, bytes, uns);

      ex_is_store = st; ex_size = 2'(sz); ex_unsigned = uns;
      ex_addr = addr; ex_wdata = wdata; ex_valid = 1'b1;
      @(negedge clk);
      chk({tag, "/ready"}, {63'd0, ex_ready}, 64'd1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      ex_wdata = {$urandom, $urandom};
      if (trap) begin
         @(negedge clk);
         chk({tag, "/trap_wbv"}, {63'd0, wb_valid}, 64'd1);
         chk({tag, "/trap_err"}, {63'd0, wb_err}, 64'd1);
         chk({tag, "/trap_data"}, wb_data, 64'd0);
         chk({tag, "/trap_req"}, {63'd0, bus.mem_req}, 64'd0);
         @(posedge clk); #1;
         $display("op %s trapped misaligned addr=%h", tag, addr);
         return;
      end
      for (int k = 0; k <= gd; k++) begin
         bus.mem_gnt    = (k == gd);
         bus.mem_rvalid = (k == gd) && !st && (rd == 0);
         bus.mem_rdata  = bus.mem_rvalid ? rdata : {$urandom, $urandom};
         @(negedge clk);
         chk({tag, "/req"}, {63'd0, bus.mem_req}, 64'd1);
         chk({tag, "/addr"}, bus.mem_addr, {addr[63:3], 3'b000});
         chk({tag, "/we"}, {63'd0, bus.mem_we}, {63'd0, st});
         chk({tag, "/stall"}, {63'd0, stall}, 64'd1);
         if (st) begin
            chk({tag, "/wmask"}, {56'd0, bus.mem_wmask}, {56'd0, mask});
            chk({tag, "/wdata"}, bus.mem_wdata, wdata << (8 * off));
         end
         @(posedge clk); #1;
      end
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      if (!st) begin
         for (int k = 1; k <= rd; k++) begin
            bus.mem_rvalid = (k == rd);
            bus.mem_rdata  = bus.mem_rvalid ? rdata : {$urandom, $urandom};
            @(negedge clk);
            chk({tag, "/wait_req"}, {63'd0, bus.mem_req}, 64'd0);
            chk({tag, "/wait_wbv"}, {63'd0, wb_valid}, 64'd0);
            @(posedge clk); #1;
         end
      end
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      chk({tag, "/wbv"}, {63'd0, wb_valid}, 64'd1);
      chk({tag, "/err"}, {63'd0, wb_err}, 64'd0);
      chk({tag, "/wbdata"}, wb_data, expd);
      @(posedge clk); #1;
      $display("op %s st=%0d size=%0d uns=%0d addr=%h wb_data=%h exp=%h", tag, st, sz, uns, addr, wb_data, expd);
   endtask

   initial begin
      int n;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
      #2;
      chk("rst/ready", {63'd0, ex_ready}, 64'd1);
      chk("rst/stall", {63'd0, stall}, 64'd0);
      chk("rst/req", {63'd0, bus.mem_req}, 64'd0);
      chk("rst/we", {63'd0, bus.mem_we}, 64'd0);
      chk("rst/addr", bus.mem_addr, 64'd0);
      chk("rst/wmask", {56'd0, bus.mem_wmask}, 64'd0);
      chk("rst/wdata", bus.mem_wdata, 64'd0);
      chk("rst/wbv", {63'd0, wb_valid}, 64'd0);
      chk("rst/wbdata", wb_data, 64'd0);
      chk("rst/err", {63'd0, wb_err}, 64'd0);
      $display("reset state checked");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      do_op(1'b0, 3, 1'b0, 64'h8000_0008, 64'd0, 64'h1122334455667788, 0, 0, "ld_min_latency");
      do_op(1'b0, 0, 1'b0, 64'h8000_0003, 64'd0, 64'h0000000080FF0000, 0, 0, "lb");
      do_op(1'b0, 0, 1'b1, 64'h8000_0003, 64'd0, 64'h0000000080FF0000, 1, 1, "lbu");
      do_op(1'b1, 1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 3, 0, "sh_gnt_delay");
      do_op(1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'h1122334455667788, 0, 0, "lw_misaligned");

      // Timeout with no grant, then with grant but no read data; late responses must be ignored.
      for (int v = 0; v < 2; v++) begin
         ex_is_store = 1'b0; ex_size = 2'd2; ex_unsigned = 1'b0;
         ex_addr = 64'h8000_0040; ex_valid = 1'b1;
         @(posedge clk); #1;
         ex_valid = 1'b0;
         n = 0;
         while (n < 40) begin
            bus.mem_gnt = (v == 1) && (n == 0);
            @(negedge clk);
            if (wb_valid) break;
            n++;
            @(posedge clk); #1;
         end
         bus.mem_gnt = 1'b0;
         chk("timeout/cycles", 64'(n), 64'(TO));
         chk("timeout/err", {63'd0, wb_err}, 64'd1);
         chk("timeout/data", wb_data, 64'd0);
         chk("timeout/req", {63'd0, bus.mem_req}, 64'd0);
         $display("timeout variant %0d: wb after %0d cycles", v, n);
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_0000_0001;
         repeat (2) begin
            @(negedge clk);
            chk("timeout/late_wbv", {63'd0, wb_valid}, 64'd0);
            @(posedge clk); #1;
         end
         bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
      end

      // Asynchronous reset while waiting for read data.
      ex_is_store = 1'b0; ex_size = 2'd3; ex_addr = 64'h8000_0010; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      @(negedge clk);
      chk("rstwait/busy", {63'd0, ex_ready}, 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("rstwait/ready", {63'd0, ex_ready}, 64'd1);
      chk("rstwait/req", {63'd0, bus.mem_req}, 64'd0);
      chk("rstwait/wbv", {63'd0, wb_valid}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
      repeat (2) begin
         @(negedge clk);
         chk("rstwait/late_wbv", {63'd0, wb_valid}, 64'd0);
         @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0;
      $display("reset mid-wait checked");
      do_op(1'b0, 3, 1'b0, 64'h8000_0018, 64'd0, 64'hCAFE_F00D_1234_5678, 0, 1, "ld_after_rst");

      for (int i = 0; i < 40; i++) begin
         do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               64'h8000_0000 + 64'($urandom_range(0, 255)), {$urandom, $urandom},
               {$urandom, $urandom}, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
